light_write_sched: RTL and testbench

Write scheduler in front of the MiniLED backlight write port (`mapped_light` / `light_index` / `light_refresh`). It arbitrates between two zone-value requesters: A, the dimming algorithm, and B, the OSD/test-pattern source. It paces the accepted writes to a programmable minimum spacing. On request it runs a self-generated blanking sweep that writes zero to every zone. The block sits between the requesters and the driver top, in the same clock domain as the driver's write port.

---
 rtl/light_write_sched.sv | 187 ++++++++++++++++++
 tb/tb_light_write_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/light_write_sched.sv
// Write scheduler for the MiniLED backlight write port. Arbitrates two zone-value
// requesters (A: dimming, B: OSD/test pattern), paces refreshes to a minimum spacing,
// and can run a self-generated zero-fill sweep across all zones.
module light_write_sched #(
  parameter int unsigned NUM_ZONES = 384,
  parameter int unsigned GAP       = 2
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        a_valid,
  input  logic [8:0]  a_index,
  input  logic [15:0] a_light,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [8:0]  b_index,
  input  logic [15:0] b_light,
  output logic        b_ready,
  input  logic        b_priority,
  input  logic        blank_req,
  output logic        blank_busy,
  output logic        blank_done,
  output logic        err_range,
  output logic        light_refresh,
  output logic [8:0]  light_index,
  output logic [15:0] mapped_light
);

  localparam logic [9:0] NumZonesW = 10'(NUM_ZONES);
  localparam logic [8:0] LastIdx   = 9'(NUM_ZONES - 1);
  localparam logic [3:0] GapCnt    = 4'(GAP);
  localparam bit         HasGap    = (GAP != 0);

  typedef enum logic [1:0] {StIdle, StCool, StBlank, StBlankCool} state_e;

  state_e      r_state, w_state_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [8:0]  r_sweep_idx, w_sweep_idx_d;
  logic        r_live;
  logic        r_last_b, w_last_b_d;
  logic        r_refresh, w_refresh_d;
  logic [8:0]  r_index, w_index_d;
  logic [15:0] r_light, w_light_d;
  logic        r_done, w_done_d;
  logic        r_err, w_err_d;

  logic        w_active;
  logic        w_blank_start;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_xfer;
  logic [8:0]  w_xfer_index;
  logic [15:0] w_xfer_light;
  logic        w_in_range;
  logic        w_sweep_issue;
  logic [8:0]  w_sweep_idx;
  logic        w_sweep_last;

  // Arbitration and transfer decode; r_live keeps readies low in the reset-release cycle.
  always_comb begin
    w_active      = r_live && (r_state == StIdle);
    w_blank_start = w_active && blank_req;
    // r_last_b = 1 means B was granted last, so A wins the next tie.
    w_grant_a     = a_valid && (!b_valid || (!b_priority && r_last_b));
    w_grant_b     = b_valid && (!a_valid || b_priority || !r_last_b);
    a_ready       = w_active && !blank_req && w_grant_a;
    b_ready       = w_active && !blank_req && w_grant_b;
    w_xfer        = a_ready || b_ready;
    w_xfer_index  = b_ready ? b_index : a_index;
    w_xfer_light  = b_ready ? b_light : a_light;
    w_in_range    = {1'b0, w_xfer_index} < NumZonesW;
    // The first sweep write is issued straight from IDLE so it lands one cycle after the request.
    w_sweep_issue = w_blank_start || (r_state == StBlank);
    w_sweep_idx   = w_blank_start ? 9'd0 : r_sweep_idx;
    w_sweep_last  = (w_sweep_idx == LastIdx);
  end

  // Next-state logic: pacing counters and sweep progress.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_sweep_idx_d = r_sweep_idx;
    if (w_sweep_issue) begin
      if (w_sweep_last) begin
        w_state_d = HasGap ? StCool : StIdle;
        w_cnt_d   = GapCnt;
      end else begin
        w_state_d     = HasGap ? StBlankCool : StBlank;
        w_cnt_d       = GapCnt - 4'd1;
        w_sweep_idx_d = w_sweep_idx + 9'd1;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          // Out-of-range transfers complete without a refresh, so no spacing follows.
          if (w_xfer && w_in_range && HasGap) begin
            w_state_d = StCool;
            w_cnt_d   = GapCnt;
          end
        end
        StCool: begin
          if (r_cnt == 4'd0) w_state_d = StIdle;
          else               w_cnt_d   = r_cnt - 4'd1;
        end
        StBlankCool: begin
          if (r_cnt == 4'd0) w_state_d = StBlank;
          else               w_cnt_d   = r_cnt - 4'd1;
        end
        StBlank: begin
          w_state_d = StBlank;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // FSM state, counters and round-robin pointer.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_sweep_idx <= 9'd0;
      r_live      <= 1'b0;
      r_last_b    <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_sweep_idx <= w_sweep_idx_d;
      r_live      <= 1'b1;
      r_last_b    <= w_last_b_d;
    end
  end

  // Next values of the registered write port, done pulse, error flag and pointer.
  always_comb begin
    w_refresh_d = 1'b0;
    w_index_d   = r_index;
    w_light_d   = r_light;
    w_done_d    = 1'b0;
    w_err_d     = r_err;
    w_last_b_d  = r_last_b;
    if (w_sweep_issue) begin
      w_refresh_d = 1'b1;
      w_index_d   = w_sweep_idx;
      w_light_d   = 16'h0000;
      w_done_d    = w_sweep_last;
    end else if (w_xfer) begin
      w_last_b_d = b_ready;
      if (w_in_range) begin
        w_refresh_d = 1'b1;
        w_index_d   = w_xfer_index;
        w_light_d   = w_xfer_light;
      end else begin
        w_err_d = 1'b1;
      end
    end
  end

  // Registered driver-side outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_refresh <= 1'b0;
      r_index   <= 9'd0;
      r_light   <= 16'h0000;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_refresh <= w_refresh_d;
      r_index   <= w_index_d;
      r_light   <= w_light_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
    end
  end

  // Busy covers the sweep states plus the cycle carrying the final sweep refresh.
  always_comb begin
    blank_busy    = (r_state == StBlank) || (r_state == StBlankCool) || r_done;
    blank_done    = r_done;
    err_range     = r_err;
    light_refresh = r_refresh;
    light_index   = r_index;
    mapped_light  = r_light;
  end

endmodule

// File: tb/tb_light_write_sched.sv
// Directed bench for light_write_sched. Three instances share the stimulus:
// [0] NUM_ZONES=384 GAP=2, [1] NUM_ZONES=384 GAP=0, [2] NUM_ZONES=8 GAP=1.
module tb_light_write_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, b_priority, blank_req;
  logic [8:0]  a_index, b_index;
  logic [15:0] a_light, b_light;

  logic        a_rdy   [3];
  logic        b_rdy   [3];
  logic        busy    [3];
  logic        done    [3];
  logic        err     [3];
  logic        refresh [3];
  logic [8:0]  l_idx   [3];
  logic [15:0] l_val   [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  light_write_sched #(.NUM_ZONES(384), .GAP(2)) u_g2 (
    .I_clk(clk), .I_rst_n(rst_n),
    .a_valid(a_valid), .a_index(a_index), .a_light(a_light), .a_ready(a_rdy[0]),
    .b_valid(b_valid), .b_index(b_index), .b_light(b_light), .b_ready(b_rdy[0]),
    .b_priority(b_priority), .blank_req(blank_req), .blank_busy(busy[0]),
    .blank_done(done[0]), .err_range(err[0]), .light_refresh(refresh[0]),
    .light_index(l_idx[0]), .mapped_light(l_val[0])
  );

  light_write_sched #(.NUM_ZONES(384), .GAP(0)) u_g0 (
    .I_clk(clk), .I_rst_n(rst_n),
    .a_valid(a_valid), .a_index(a_index), .a_light(a_light), .a_ready(a_rdy[1]),
    .b_valid(b_valid), .b_index(b_index), .b_light(b_light), .b_ready(b_rdy[1]),
    .b_priority(b_priority), .blank_req(blank_req), .blank_busy(busy[1]),
    .blank_done(done[1]), .err_range(err[1]), .light_refresh(refresh[1]),
    .light_index(l_idx[1]), .mapped_light(l_val[1])
  );

  light_write_sched #(.NUM_ZONES(8), .GAP(1)) u_bl (
    .I_clk(clk), .I_rst_n(rst_n),
    .a_valid(a_valid), .a_index(a_index), .a_light(a_light), .a_ready(a_rdy[2]),
    .b_valid(b_valid), .b_index(b_index), .b_light(b_light), .b_ready(b_rdy[2]),
    .b_priority(b_priority), .blank_req(blank_req), .blank_busy(busy[2]),
    .blank_done(done[2]), .err_range(err[2]), .light_refresh(refresh[2]),
    .light_index(l_idx[2]), .mapped_light(l_val[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    a_valid    = 1'b0;
    b_valid    = 1'b0;
    b_priority = 1'b0;
    blank_req  = 1'b0;
    a_index    = 9'd0;
    b_index    = 9'd0;
    a_light    = 16'h0000;
    b_light    = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int refreshes;
    idle_inputs();
    rst_n = 1'b0;

    // Reset values and readies held low in the reset-release cycle.
    #12;
    chk("rst_refresh", refresh[0], 1'b0);
    chk("rst_index", l_idx[0], 9'd0);
    chk("rst_light", l_val[0], 16'h0000);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_done", done[0], 1'b0);
    chk("rst_err", err[0], 1'b0);
    a_valid = 1'b1;
    a_index = 9'd5;
    a_light = 16'h1234;
    #5;
    rst_n = 1'b1;
    #1;
    chk("rst_release_a_ready", a_rdy[0], 1'b0);

    // Single A write, GAP=2: refresh at t+1, readies low t+1..t+3, accept at t+4.
    step();
    chk("single_ready_t", a_rdy[0], 1'b1);
    step();
    chk("single_refresh_t1", refresh[0], 1'b1);
    chk("single_index_t1", l_idx[0], 9'd5);
    chk("single_light_t1", l_val[0], 16'h1234);
    chk("single_ready_t1", a_rdy[0], 1'b0);
    step();
    chk("single_refresh_t2", refresh[0], 1'b0);
    chk("single_ready_t2", a_rdy[0], 1'b0);
    step();
    chk("single_ready_t3", a_rdy[0], 1'b0);
    step();
    chk("single_ready_t4", a_rdy[0], 1'b1);
    a_valid = 1'b0;

    // Round-robin with GAP=0: A wins the first tie, then B, A, B; refresh every cycle.
    do_reset();
    a_valid = 1'b1; a_index = 9'd10; a_light = 16'hAA00;
    b_valid = 1'b1; b_index = 9'd20; b_light = 16'hBB00;
    for (int i = 0; i < 4; i++) begin
      logic exp_a;
      logic [8:0]  e_idx;
      logic [15:0] e_val;
      exp_a = (i % 2) == 0;
      e_idx = exp_a ? a_index : b_index;
      e_val = exp_a ? a_light : b_light;
      #1;
      chk("rr_a_ready", a_rdy[1], exp_a);
      chk("rr_b_ready", b_rdy[1], !exp_a);
      step();
      chk("rr_refresh", refresh[1], 1'b1);
      chk("rr_index", l_idx[1], e_idx);
      chk("rr_light", l_val[1], e_val);
      if (exp_a) begin a_index = a_index + 9'd1; a_light = a_light + 16'd1; end
      else       begin b_index = b_index + 9'd1; b_light = b_light + 16'd1; end
    end

    // Strict priority: B takes four writes while A waits, A goes once B drops.
    b_priority = 1'b1;
    a_index = 9'd30; a_light = 16'hA0A0;
    b_index = 9'd40; b_light = 16'hB0B0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("prio_b_ready", b_rdy[1], 1'b1);
      chk("prio_a_ready", a_rdy[1], 1'b0);
      step();
      chk("prio_index", l_idx[1], 9'd40 + 9'(i));
      chk("prio_light", l_val[1], 16'hB0B0);
      b_index = b_index + 9'd1;
    end
    b_valid = 1'b0;
    #1;
    chk("prio_a_after_b", a_rdy[1], 1'b1);
    step();
    chk("prio_a_index", l_idx[1], 9'd30);
    chk("prio_a_light", l_val[1], 16'hA0A0);
    a_valid = 1'b0;

    // Range error: index 400 completes without refresh, error is sticky, next write is normal.
    do_reset();
    a_valid = 1'b1; a_index = 9'd400; a_light = 16'h5555;
    #1;
    chk("range_ready", a_rdy[0], 1'b1);
    step();
    chk("range_no_refresh", refresh[0], 1'b0);
    chk("range_index_hold", l_idx[0], 9'd0);
    chk("range_light_hold", l_val[0], 16'h0000);
    chk("range_err_set", err[0], 1'b1);
    a_index = 9'd7; a_light = 16'h7777;
    #1;
    chk("range_no_cool", a_rdy[0], 1'b1);
    step();
    chk("range_next_refresh", refresh[0], 1'b1);
    chk("range_next_index", l_idx[0], 9'd7);
    chk("range_next_light", l_val[0], 16'h7777);
    a_valid = 1'b0;
    repeat (3) step();
    chk("range_err_sticky", err[0], 1'b1);

    // Blank sweep on 8 zones, GAP=1: refreshes every 2 cycles, done with index 7.
    do_reset();
    a_valid = 1'b1; a_index = 9'd3; a_light = 16'hABCD;
    blank_req = 1'b1;
    #1;
    chk("blank_wins_a_ready", a_rdy[2], 1'b0);
    chk("blank_busy_before", busy[2], 1'b0);
    step();
    blank_req = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      logic is_ref;
      is_ref = (c % 2) == 1;
      chk("sweep_refresh", refresh[2], is_ref);
      chk("sweep_busy", busy[2], 1'b1);
      chk("sweep_a_ready", a_rdy[2], 1'b0);
      if (is_ref) begin
        chk("sweep_index", l_idx[2], 9'((c - 1) / 2));
        chk("sweep_light", l_val[2], 16'h0000);
        chk("sweep_done", done[2], c == 15);
      end else begin
        chk("sweep_done_idle", done[2], 1'b0);
      end
      if (c < 15) step();
    end
    for (int k = 0; k < 8; k++) begin
      step();
      if (a_rdy[2]) break;
    end
    chk("blank_a_served", a_rdy[2], 1'b1);
    chk("blank_busy_after", busy[2], 1'b0);
    step();
    chk("blank_a_refresh", refresh[2], 1'b1);
    chk("blank_a_index", l_idx[2], 9'd3);
    chk("blank_a_light", l_val[2], 16'hABCD);
    a_valid = 1'b0;

    // Reset mid-sweep at index 3: asynchronous clear, no refresh afterwards.
    do_reset();
    blank_req = 1'b1;
    step();
    blank_req = 1'b0;
    repeat (6) step();
    chk("midrst_pre_refresh", refresh[2], 1'b1);
    chk("midrst_pre_index", l_idx[2], 9'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_refresh", refresh[2], 1'b0);
    chk("midrst_index", l_idx[2], 9'd0);
    chk("midrst_light", l_val[2], 16'h0000);
    chk("midrst_busy", busy[2], 1'b0);
    chk("midrst_done", done[2], 1'b0);
    chk("midrst_err", err[2], 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    refreshes = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (refresh[2]) refreshes++;
    end
    chk("midrst_no_refresh", 32'(refreshes), 32'd0);
    chk("midrst_busy_after", busy[2], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
